model_read_keys_transmitter: RTL and testbench
==============================================

Name: model_read_keys_transmitter

Overview:
- Producer end of the read-key stream interface of the DNC read heads.
- Walks the R×W read-key matrix k^(t;i;k) held in an external key memory, issuing one read per cycle.
- Emits the matrix row-major as a flat word stream. K_OUT_I_ENABLE flags the first word of each row i; K_OUT_K_ENABLE flags every word.
- Drives the K_IN / K_IN_I_ENABLE / K_IN_K_ENABLE inputs of the read-key consumer stage.

Parameters:
- DATA_SIZE, 64, width of key words, sizes and memory address.
- CONTROL_SIZE, 64, width of the internal i/k loop counters.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  starts one matrix transfer; sampled only in IDLE.
- HOLD  input  1  while high, no new memory read is issued.
- READY  output  1  one-cycle pulse, coincident with the last emitted word (or the empty-matrix completion).
- SIZE_R_IN  input  DATA_SIZE  R, number of read heads; sampled at START.
- SIZE_W_IN  input  DATA_SIZE  W, word width; sampled at START.
- K_RD_ENABLE  output  1  memory read strobe.
- K_ADDR_OUT  output  DATA_SIZE  memory address, equal to i*W+k.
- K_RD_DATA_IN  input  DATA_SIZE  memory data; valid in the cycle after K_RD_ENABLE.
- K_OUT  output  DATA_SIZE  key word k(t;i;k).
- K_OUT_I_ENABLE  output  1  high with the word where k=0 (new row i).
- K_OUT_K_ENABLE  output  1  high with every emitted word.

Behaviour:
- Reset (async, RST=1), all outputs 0:
  - READY, K_RD_ENABLE, K_ADDR_OUT, K_OUT, K_OUT_I_ENABLE, K_OUT_K_ENABLE all 0.
  - Counters i, k, address, and pipeline valid/first flags all 0.
  - State IDLE.
  - Reset mid-transfer aborts with no READY; a word in flight is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - START=1 latches R and W, clears i, k and address.
  - If R=0 or W=0: READY=1 in the next cycle, no reads, stay IDLE.
  - Otherwise go to ISSUE.
  - START is ignored in ISSUE and DRAIN.
- ISSUE, cycle with HOLD=0:
  - K_RD_ENABLE=1 and K_ADDR_OUT=address are registered for the current (i,k).
  - A pipeline valid bit and a first-of-row bit (k==0) are registered alongside.
  - Counter advance:
    - k<W-1: k+1.
    - Else: k=0, i+1.
  - Address increments by 1 on every issue; it is a running counter, no multiplier.
  - Issuing (R-1,W-1) moves the FSM to DRAIN.
- ISSUE, cycle with HOLD=1: K_RD_ENABLE=0, counters frozen, state unchanged.
- Emit stage (every state):
  - Pipeline valid=1: K_OUT<=K_RD_DATA_IN, K_OUT_K_ENABLE<=1, K_OUT_I_ENABLE<=first bit.
  - Pipeline valid=0: both enables <=0 and K_OUT holds its value.
  - Latency: a word appears on K_OUT exactly one cycle after its K_RD_ENABLE cycle.
  - HOLD never stalls a word already in flight.
- DRAIN:
  - K_RD_ENABLE=0.
  - When the last word is emitted, READY=1 in the same cycle as its K_OUT_K_ENABLE.
  - Next state IDLE; READY returns to 0 the following cycle.
- Throughput: R*W words in R*W + 1 cycles from the first issue, when HOLD stays low.
- Comparisons are unsigned. SIZE inputs are truncated to CONTROL_SIZE for the loop counters.
- Address wraps modulo 2^DATA_SIZE; wrap is not detected.

Test Plan:
- Reset during ISSUE at R=2,W=3 after 2 issues -> all outputs 0 immediately (async); no READY; a following START restarts at address 0.
- R=2,W=3, memory[a]=0x10+a, HOLD=0 -> K_OUT = 0x10..0x15 on 6 consecutive cycles, one cycle after reads 0..5. K_OUT_I_ENABLE high on 0x10 and 0x13 only. READY high with 0x15 only.
- Same sizes, HOLD=1 for 2 cycles after the 2nd issue -> K_RD_ENABLE low for those 2 cycles. Word 0x11 is still emitted during HOLD. Stream resumes at address 2; 6 words total, READY with 0x15.
- R=1,W=1 -> one read at address 0; K_OUT with I and K enables both high; READY in the same cycle.
- R=0 (any W), then W=0 (any R) -> READY pulse the cycle after START; no K_RD_ENABLE; no K_OUT enables.
- START pulsed again mid-transfer (R=3,W=2) -> ignored; exactly 6 words emitted; next START after READY accepted and repeats the stream.

Source files
------------

// File: rtl/model_read_keys_transmitter_if.sv
// Read-key stream bundle: control handshake, key-memory read port and key word output.
interface model_read_keys_transmitter_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 HOLD;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_R_IN;
  logic [DATA_SIZE-1:0] SIZE_W_IN;
  logic                 K_RD_ENABLE;
  logic [DATA_SIZE-1:0] K_ADDR_OUT;
  logic [DATA_SIZE-1:0] K_RD_DATA_IN;
  logic [DATA_SIZE-1:0] K_OUT;
  logic                 K_OUT_I_ENABLE;
  logic                 K_OUT_K_ENABLE;

  modport master (
    input  START, HOLD, SIZE_R_IN, SIZE_W_IN, K_RD_DATA_IN,
    output READY, K_RD_ENABLE, K_ADDR_OUT, K_OUT, K_OUT_I_ENABLE, K_OUT_K_ENABLE
  );

  modport slave (
    output START, HOLD, SIZE_R_IN, SIZE_W_IN, K_RD_DATA_IN,
    input  READY, K_RD_ENABLE, K_ADDR_OUT, K_OUT, K_OUT_I_ENABLE, K_OUT_K_ENABLE
  );
endinterface

// File: rtl/model_read_keys_transmitter.sv
// Walks the R x W read-key matrix in key memory row-major and streams it out,
// one memory read per cycle, each word emitted one cycle after its read.
//
//   state | meaning
//   IDLE  | waiting for START; empty matrices complete here
//   ISSUE | issuing one read per cycle unless HOLD is high
//   DRAIN | all reads issued, waiting for the last word to be emitted
module model_read_keys_transmitter #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input logic                          CLK,
  input logic                          RST,
  model_read_keys_transmitter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t                  state;
  logic [CONTROL_SIZE-1:0] size_r;
  logic [CONTROL_SIZE-1:0] size_w;
  logic [CONTROL_SIZE-1:0] i_cnt;
  logic [CONTROL_SIZE-1:0] k_cnt;
  logic [DATA_SIZE-1:0]    addr;
  logic                    pipe_valid;
  logic                    pipe_first;
  logic                    pipe_last;

  logic [CONTROL_SIZE-1:0] start_r;
  logic [CONTROL_SIZE-1:0] start_w;
  logic                    row_end;
  logic                    mat_end;

  assign start_r = CONTROL_SIZE'(bus.SIZE_R_IN);
  assign start_w = CONTROL_SIZE'(bus.SIZE_W_IN);
  assign row_end = (k_cnt == size_w - CONTROL_SIZE'(1));
  assign mat_end = row_end && (i_cnt == size_r - CONTROL_SIZE'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state              <= IDLE;
      size_r             <= '0;
      size_w             <= '0;
      i_cnt              <= '0;
      k_cnt              <= '0;
      addr               <= '0;
      pipe_valid         <= 1'b0;
      pipe_first         <= 1'b0;
      pipe_last          <= 1'b0;
      bus.READY          <= 1'b0;
      bus.K_RD_ENABLE    <= 1'b0;
      bus.K_ADDR_OUT     <= '0;
      bus.K_OUT          <= '0;
      bus.K_OUT_I_ENABLE <= 1'b0;
      bus.K_OUT_K_ENABLE <= 1'b0;
    end else begin
      bus.READY       <= 1'b0;
      bus.K_RD_ENABLE <= 1'b0;
      pipe_valid      <= 1'b0;

      // Emit stage runs in every state so HOLD never stalls a word in flight.
      if (pipe_valid) begin
        bus.K_OUT          <= bus.K_RD_DATA_IN;
        bus.K_OUT_K_ENABLE <= 1'b1;
        bus.K_OUT_I_ENABLE <= pipe_first;
      end else begin
        bus.K_OUT_K_ENABLE <= 1'b0;
        bus.K_OUT_I_ENABLE <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.START) begin
            size_r <= start_r;
            size_w <= start_w;
            i_cnt  <= '0;
            k_cnt  <= '0;
            addr   <= '0;
            if (start_r == '0 || start_w == '0) begin
              bus.READY <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (!bus.HOLD) begin
            bus.K_RD_ENABLE <= 1'b1;
            bus.K_ADDR_OUT  <= addr;
            pipe_valid      <= 1'b1;
            pipe_first      <= (k_cnt == '0);
            pipe_last       <= mat_end;
            // Running address replaces i*W+k; wraps silently.
            addr            <= addr + DATA_SIZE'(1);
            if (row_end) begin
              k_cnt <= '0;
              i_cnt <= i_cnt + CONTROL_SIZE'(1);
            end else begin
              k_cnt <= k_cnt + CONTROL_SIZE'(1);
            end
            if (mat_end) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (pipe_valid && pipe_last) begin
            bus.READY <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_read_keys_transmitter.sv
// Scoreboard bench: stimulus pushes expected reads and words, monitors pop and compare.
module tb_model_read_keys_transmitter;

  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          i_en;
    logic          k_en;
    logic          ready;
  } exp_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   checks;
  int   failures;

  exp_t          exp_q[$];
  logic [DW-1:0] addr_q[$];
  int            rdcyc_q[$];

  model_read_keys_transmitter_if #(.DATA_SIZE(DW)) bus ();

  model_read_keys_transmitter #(.DATA_SIZE(DW), .CONTROL_SIZE(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // Combinational key memory: mem[a] = 0x10 + a
  assign bus.K_RD_DATA_IN = 64'h10 + bus.K_ADDR_OUT;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Read-port monitor
  always @(negedge CLK) begin
    if (!RST && bus.K_RD_ENABLE) begin
      checks++;
      if (addr_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: addr=%0h with no read expected", bus.K_ADDR_OUT);
      end else begin
        logic [DW-1:0] a;
        a = addr_q.pop_front();
        rdcyc_q.push_back(cyc);
        if (bus.K_ADDR_OUT !== a) begin
          failures++;
          $display("FAIL rd_addr: got=%0h want=%0h", bus.K_ADDR_OUT, a);
        end
      end
    end
  end

  // Output-stream monitor
  always @(negedge CLK) begin
    if (!RST && (bus.K_OUT_K_ENABLE || bus.K_OUT_I_ENABLE || bus.READY)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: k_en=%0b i_en=%0b ready=%0b data=%0h",
                 bus.K_OUT_K_ENABLE, bus.K_OUT_I_ENABLE, bus.READY, bus.K_OUT);
      end else begin
        exp_t e;
        logic bad;
        int   rc;
        e   = exp_q.pop_front();
        bad = (bus.K_OUT_K_ENABLE !== e.k_en) || (bus.K_OUT_I_ENABLE !== e.i_en) ||
              (bus.READY !== e.ready) || (e.k_en && bus.K_OUT !== e.data);
        if (e.k_en) begin
          if (rdcyc_q.size() == 0) begin
            bad = 1'b1;
            rc  = -10;
          end else begin
            rc = rdcyc_q.pop_front();
          end
          if (cyc != rc + 1) bad = 1'b1;
        end
        if (bad) begin
          failures++;
          $display("FAIL out_word: got data=%0h i=%0b k=%0b rdy=%0b want data=%0h i=%0b k=%0b rdy=%0b",
                   bus.K_OUT, bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE, bus.READY,
                   e.data, e.i_en, e.k_en, e.ready);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_stream(input int r, input int w);
    for (int i = 0; i < r; i++) begin
      for (int k = 0; k < w; k++) begin
        exp_t e;
        e.data  = 64'h10 + 64'(i * w + k);
        e.i_en  = (k == 0);
        e.k_en  = 1'b1;
        e.ready = (i == r - 1) && (k == w - 1);
        exp_q.push_back(e);
        addr_q.push_back(64'(i * w + k));
      end
    end
  endtask

  task automatic push_empty();
    exp_t e;
    e.data  = '0;
    e.i_en  = 1'b0;
    e.k_en  = 1'b0;
    e.ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic clear_q();
    exp_q.delete();
    addr_q.delete();
    rdcyc_q.delete();
  endtask

  // Drive START for one cycle; returns at the negedge after the sampling edge.
  task automatic pulse_start(input int r, input int w);
    @(negedge CLK);
    bus.SIZE_R_IN = 64'(r);
    bus.SIZE_W_IN = 64'(w);
    bus.START     = 1'b1;
    @(negedge CLK);
    bus.START     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK);
      #2;
      if (exp_q.size() == 0 && addr_q.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: pending_out=%0d pending_rd=%0d", name, exp_q.size(), addr_q.size());
      clear_q();
    end
    @(negedge CLK);
    #2;
    check({name, "_ready_low"}, 64'(bus.READY), 64'd0);
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    failures      = 0;
    RST           = 1'b1;
    bus.START     = 1'b0;
    bus.HOLD      = 1'b0;
    bus.SIZE_R_IN = '0;
    bus.SIZE_W_IN = '0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 64'(bus.READY), 64'd0);
    check("rst_rd_en", 64'(bus.K_RD_ENABLE), 64'd0);
    check("rst_addr", bus.K_ADDR_OUT, 64'd0);
    check("rst_kout", bus.K_OUT, 64'd0);
    check("rst_en", {62'd0, bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE}, 64'd0);
    RST = 1'b0;

    // Reset mid-transfer after two issues
    push_stream(2, 3);
    pulse_start(2, 3);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("pre_rst_rd_en", 64'(bus.K_RD_ENABLE), 64'd1);
    RST = 1'b1;
    #1;
    check("arst_rd_en", 64'(bus.K_RD_ENABLE), 64'd0);
    check("arst_addr", bus.K_ADDR_OUT, 64'd0);
    check("arst_kout", bus.K_OUT, 64'd0);
    check("arst_en_rdy", {61'd0, bus.READY, bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE}, 64'd0);
    clear_q();
    @(negedge CLK);
    RST = 1'b0;

    // Full 2x3 stream, restarting at address 0
    push_stream(2, 3);
    pulse_start(2, 3);
    wait_done("r2w3", 40);

    // HOLD for two cycles after the second issue
    push_stream(2, 3);
    pulse_start(2, 3);
    @(negedge CLK);
    @(negedge CLK);
    bus.HOLD = 1'b1;
    @(negedge CLK);
    #1;
    check("hold1_rd_en", 64'(bus.K_RD_ENABLE), 64'd0);
    check("hold1_word", {62'd0, bus.K_OUT_K_ENABLE, 1'b0} | 64'(bus.K_OUT == 64'h11), 64'd3);
    @(negedge CLK);
    #1;
    check("hold2_rd_en", 64'(bus.K_RD_ENABLE), 64'd0);
    bus.HOLD = 1'b0;
    wait_done("hold", 40);

    // 1x1 matrix
    push_stream(1, 1);
    pulse_start(1, 1);
    wait_done("r1w1", 20);

    // Empty matrices
    push_empty();
    pulse_start(0, 5);
    #1;
    check("r0_ready", 64'(bus.READY), 64'd1);
    wait_done("r0", 10);
    push_empty();
    pulse_start(4, 0);
    #1;
    check("w0_ready", 64'(bus.READY), 64'd1);
    wait_done("w0", 10);

    // START re-pulsed mid-transfer is ignored
    push_stream(3, 2);
    pulse_start(3, 2);
    @(negedge CLK);
    pulse_start(5, 5);
    wait_done("restart_ign", 40);
    push_stream(3, 2);
    pulse_start(3, 2);
    wait_done("repeat", 40);

    repeat (3) @(negedge CLK);
    #2;
    check("final_pending", 64'(exp_q.size() + addr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
